soc_onchip_mem_engine: RTL and testbench
========================================

# soc_onchip_mem_engine

Avalon-MM master that drives the single-port on-chip memory's slave port and moves data under control of a simple start/done command interface. Supports block fill, block copy and a 32-bit additive checksum over a word range, offloading bulk memory work from the Nios II CPU. It sits beside the CPU in the SoC and connects to the memory's second slave port through the interconnect.

## Interface
Parameters:
- ADDR_W, 15, word address width of the memory port
- DATA_W, 32, data width (byteenable width = DATA_W/8)
- DEPTH, 32036, number of valid words in the memory

Ports:
- clk  in  1  system clock; everything is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- mode  in  2  0=FILL, 1=COPY, 2=CHECKSUM, 3=reserved (rejected with error)
- src_addr  in  ADDR_W  first source word (COPY, CHECKSUM)
- dst_addr  in  ADDR_W  first destination word (COPY, FILL)
- length  in  16  word count, 0..DEPTH
- fill_data  in  DATA_W  FILL pattern
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle pulse coincident with done on a rejected command
- checksum  out  DATA_W  result of the last CHECKSUM
- m_address  out  ADDR_W  memory word address
- m_byteenable  out  DATA_W/8  constant all-ones
- m_chipselect  out  1  access strobe
- m_write  out  1  write qualifier
- m_writedata  out  DATA_W  write data
- m_clken  out  1  memory clock enable, constant 1 out of reset
- m_readdata  in  DATA_W  read data, valid the cycle after the read address

## Operation
- States: IDLE, FILL, COPY_RD, COPY_WR, SUM, SUM_LAST, DONE.
- IDLE + start: latch all command inputs. Rejections (go to DONE with error): mode=3; src_addr+length > DEPTH (COPY/CHECKSUM); dst_addr+length > DEPTH (COPY/FILL). Bound sums computed at ADDR_W+2 bits, no wrap. length=0 and valid: DONE, no error, no access.
- FILL: one write per cycle of fill_data to dst+i, i=0..N-1; after the last write go to DONE.
- COPY: COPY_RD issues read at src+i; COPY_WR writes m_readdata to dst+i; alternate. Always ascending; overlapping ranges with dst>src propagate source data forward (documented behaviour, not an error).
- CHECKSUM: checksum cleared at start; SUM issues reads src+i every cycle; each m_readdata is added modulo 2^DATA_W the cycle it is valid; SUM_LAST absorbs the final word.
- DONE: pulse done (and error if rejected), return to IDLE.
- start outside IDLE is ignored. m_chipselect is low whenever no access is issued; m_write is low on reads.
- Reset values: busy, done, error, m_chipselect, m_write = 0; m_address, m_writedata, checksum = 0; m_byteenable = all-ones; m_clken = 1. Reset mid-command aborts immediately; a partial fill/copy stays in memory.

## Timing
- start sampled at edge T. First access in cycle T+1. busy high from T+1 through the done cycle inclusive.
- FILL N: writes T+1..T+N, done T+N+1.
- COPY N: reads T+1,T+3,..; writes T+2,T+4,..; last write T+2N, done T+2N+1.
- CHECKSUM N: reads T+1..T+N, data T+2..T+N+1, done T+N+2, checksum valid at done and held until the next CHECKSUM start.
- Rejected or length=0: done (and error) at T+1, no chipselect.

## Structure
- Package soc_mem_pkg: ADDR_W/DATA_W/DEPTH defaults, mode encoding, state encoding.
- One sub-module: soc_mem_addr_ctr (loadable base + incrementing offset, terminal-count flag), instantiated for source and destination.

## Test plan
- FILL dst=0x100, len=4, fill_data=0xDEADBEEF -> 4 writes at 0x100..0x103 in consecutive cycles, done at T+5, memory readback matches.
- COPY src=0x000, dst=0x200, len=3 after preloading 1,2,3 -> reads/writes alternate, done at T+7, 0x200..0x202 = 1,2,3.
- CHECKSUM src=0x010, len=3 over 0xFFFFFFFF,2,3 -> checksum=0x00000004 (wrap), done at T+5.
- FILL dst=32030, len=7 -> done+error at T+1, no chipselect; len=6 accepted and writes to 32035.
- mode=3 or length=0 -> done at T+1, error only for mode=3; start pulsed while busy ignored.
- Assert reset_n low mid-COPY -> all outputs at reset values same cycle, subsequent FILL runs normally.

Source files
------------

// File: rtl/soc_mem_pkg.sv
// ---------------------------------------------------------------------------
// soc_mem_pkg
// Shared definitions for the on-chip memory engine:
//   - default memory geometry (address width, data width, valid depth)
//   - command length width
//   - command mode encoding (FILL / COPY / CHECKSUM / reserved)
//   - engine state encoding, kept as plain constants so that older tools and
//     waveform scripts that expect numeric state codes keep working
// No ports: package only.
// ---------------------------------------------------------------------------
package soc_mem_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32036;
  localparam int LEN_W      = 16;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_FILL = 2'd0;
  localparam mode_t MODE_COPY = 2'd1;
  localparam mode_t MODE_SUM  = 2'd2;
  localparam mode_t MODE_RSVD = 2'd3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_FILL     = 3'd1;
  localparam state_t ST_COPY_RD  = 3'd2;
  localparam state_t ST_COPY_WR  = 3'd3;
  localparam state_t ST_SUM      = 3'd4;
  localparam state_t ST_SUM_LAST = 3'd5;
  localparam state_t ST_DONE     = 3'd6;

  // True for states that put a read on the memory port this cycle.
  function automatic logic state_reads(input state_t s);
    return (s == ST_COPY_RD) || (s == ST_SUM);
  endfunction

  // True for states that put a write on the memory port this cycle.
  function automatic logic state_writes(input state_t s);
    return (s == ST_FILL) || (s == ST_COPY_WR);
  endfunction

endpackage

// File: rtl/soc_mem_addr_ctr.sv
// ---------------------------------------------------------------------------
// soc_mem_addr_ctr
// Walks a block of word addresses: a base address and a length are captured
// on i_load, and every i_inc advances an offset by one word.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   i_load        capture i_base / i_len and restart the offset at zero
//   i_inc         advance to the next word (ignored while i_load is high)
//   i_base        first word address of the block
//   i_len         number of words in the block
//   o_addr        base + current offset
//   o_last        current offset is the final word of the block
// ---------------------------------------------------------------------------
module soc_mem_addr_ctr #(
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_offset;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_offset_next;

  assign w_offset_next = r_offset + LEN_W'(1);

  // The caller only starts a block that has already been bounds-checked, so
  // the address sum never needs to carry past the memory depth.
  assign o_addr = r_base + ADDR_W'(r_offset);
  assign o_last = (w_offset_next == r_len);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base   <= '0;
      r_offset <= '0;
      r_len    <= '0;
    end else if (i_load) begin
      r_base   <= i_base;
      r_offset <= '0;
      r_len    <= i_len;
    end else if (i_inc) begin
      r_offset <= w_offset_next;
    end
  end

endmodule

// File: rtl/soc_onchip_mem_engine.sv
// ---------------------------------------------------------------------------
// soc_onchip_mem_engine
// Avalon-MM master on the on-chip memory's second slave port. Runs block
// FILL, block COPY and a 32-bit additive CHECKSUM under a start/done
// command handshake so the CPU does not have to move bulk data itself.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   start, mode              command strobe (taken only when idle), command
//   src_addr, dst_addr       first source / destination word
//   length                   word count
//   fill_data                FILL pattern
//   busy, done, error        status: busy through the done cycle, one-cycle
//                            done pulse, error pulse with done on rejection
//   checksum                 result of the last CHECKSUM
//   m_address .. m_clken     Avalon-MM master signals to the memory
//   m_readdata               read data, valid the cycle after the read
// ---------------------------------------------------------------------------
module soc_onchip_mem_engine
  import soc_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    length,
  input  logic [DATA_W-1:0]   fill_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [DATA_W-1:0]   checksum,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic                m_clken,
  input  logic [DATA_W-1:0]   m_readdata
);

  // Two spare bits so base + length can never wrap before the depth compare.
  localparam int BW = ADDR_W + 2;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_checksum;
  logic [DATA_W-1:0] r_fill_data;

  logic [BW-1:0]     w_src_end;
  logic [BW-1:0]     w_dst_end;
  logic              w_src_oob;
  logic              w_dst_oob;
  logic              w_reject;
  logic              w_load;
  logic              w_rd;
  logic              w_wr;
  logic              w_src_inc;
  logic              w_dst_inc;
  logic [ADDR_W-1:0] w_src_addr;
  logic [ADDR_W-1:0] w_dst_addr;
  logic              w_src_last;
  logic              w_dst_last;

  assign w_src_end = BW'(src_addr) + BW'(length);
  assign w_dst_end = BW'(dst_addr) + BW'(length);
  assign w_src_oob = (w_src_end > BW'(DEPTH));
  assign w_dst_oob = (w_dst_end > BW'(DEPTH));

  // Only the ranges a mode actually touches are checked; the reserved mode
  // is always turned away.
  always_comb begin
    w_reject = 1'b0;
    case (mode)
      MODE_FILL: w_reject = w_dst_oob;
      MODE_COPY: w_reject = w_src_oob | w_dst_oob;
      MODE_SUM:  w_reject = w_src_oob;
      MODE_RSVD: w_reject = 1'b1;
    endcase
  end

  assign w_load = (r_state == ST_IDLE) & start;
  assign w_rd   = state_reads(r_state);
  assign w_wr   = state_writes(r_state);

  // Source advances after each COPY write (ready for the next read) and
  // after each CHECKSUM read; destination advances after every write.
  assign w_src_inc = ((r_state == ST_SUM) & ~w_src_last) |
                     ((r_state == ST_COPY_WR) & ~w_dst_last);
  assign w_dst_inc = w_wr & ~w_dst_last;

  soc_mem_addr_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_src_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_inc   (w_src_inc),
    .i_base  (src_addr),
    .i_len   (length),
    .o_addr  (w_src_addr),
    .o_last  (w_src_last)
  );

  soc_mem_addr_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_dst_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_inc   (w_dst_inc),
    .i_base  (dst_addr),
    .i_len   (length),
    .o_addr  (w_dst_addr),
    .o_last  (w_dst_last)
  );

  // Bus strobes decode straight from the state register, so a reset drops
  // them in the same cycle. The address is parked at zero when idle.
  always_comb begin
    m_address = '0;
    if (w_wr) begin
      m_address = w_dst_addr;
    end else if (w_rd) begin
      m_address = w_src_addr;
    end
  end

  // COPY forwards read data to the write port in the cycle it arrives, which
  // is what lets a read and its write sit in back-to-back cycles.
  assign m_writedata  = (r_state == ST_COPY_WR) ? m_readdata : r_fill_data;
  assign m_chipselect = w_rd | w_wr;
  assign m_write      = w_wr;
  assign m_byteenable = '1;
  assign m_clken      = 1'b1;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign checksum     = r_checksum;

  // Command sequencer. r_rd_valid marks cycles where m_readdata carries the
  // word requested one cycle earlier; SUM_LAST exists only to absorb the
  // final word after the last read has gone out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_checksum  <= '0;
      r_fill_data <= '0;
    end else begin
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_rd_valid <= w_rd;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy      <= 1'b1;
            r_fill_data <= fill_data;
            if (w_reject || (length == '0)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_error <= w_reject;
            end else begin
              case (mode)
                MODE_FILL: r_state <= ST_FILL;
                MODE_COPY: r_state <= ST_COPY_RD;
                default: begin
                  r_state    <= ST_SUM;
                  r_checksum <= '0;
                end
              endcase
            end
          end
        end
        ST_FILL: begin
          if (w_dst_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_COPY_RD: begin
          r_state <= ST_COPY_WR;
        end
        ST_COPY_WR: begin
          if (w_dst_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_COPY_RD;
          end
        end
        ST_SUM: begin
          if (r_rd_valid) begin
            r_checksum <= r_checksum + m_readdata;
          end
          if (w_src_last) begin
            r_state <= ST_SUM_LAST;
          end
        end
        ST_SUM_LAST: begin
          r_checksum <= r_checksum + m_readdata;
          r_state    <= ST_DONE;
          r_done     <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_onchip_mem_engine.sv
// ---------------------------------------------------------------------------
// tb_soc_onchip_mem_engine
// Directed bench for the memory engine. Each command pushes the bus accesses
// and done pulse it must produce (with cycle numbers) into a queue; a monitor
// pops and compares them whenever the engine drives the bus or pulses done.
// A behavioural one-cycle-latency memory sits on the master port.
// ---------------------------------------------------------------------------
module tb_soc_onchip_mem_engine;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32036;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                start;
  logic [1:0]          mode;
  logic [ADDR_W-1:0]   src_addr;
  logic [ADDR_W-1:0]   dst_addr;
  logic [15:0]         length;
  logic [DATA_W-1:0]   fill_data;
  logic                busy;
  logic                done;
  logic                error;
  logic [DATA_W-1:0]   checksum;
  logic [ADDR_W-1:0]   m_address;
  logic [DATA_W/8-1:0] m_byteenable;
  logic                m_chipselect;
  logic                m_write;
  logic [DATA_W-1:0]   m_writedata;
  logic                m_clken;
  logic [DATA_W-1:0]   m_readdata;

  soc_onchip_mem_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .mode         (mode),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .length       (length),
    .fill_data    (fill_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .checksum     (checksum),
    .m_address    (m_address),
    .m_byteenable (m_byteenable),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_writedata  (m_writedata),
    .m_clken      (m_clken),
    .m_readdata   (m_readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          addr;
    logic [31:0] data;
    logic        err;
    logic        chk;
    int          cyc;
  } ev_t;

  ev_t         expQ[$];
  logic [31:0] shadow [int];
  int          vecCount = 0;
  int          missCount = 0;
  int          cycNum = 0;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic              preWe;
  logic [ADDR_W-1:0] preAddr;
  logic [DATA_W-1:0] preData;

  // Memory model: registered read data one cycle after the read address,
  // plus a backdoor write port used to preload test data while idle.
  always @(posedge clk) begin
    if (preWe) begin
      mem[preAddr] <= preData;
    end else if (m_chipselect && m_write) begin
      mem[m_address] <= m_writedata;
    end
    if (m_chipselect && !m_write) begin
      m_readdata <= mem[m_address];
    end
  end

  // Cycle count: after edge k the count reads k.
  always @(posedge clk) begin
    cycNum <= cycNum + 1;
  end

  function automatic void pushEv(input int kind, input int addr, input logic [31:0] data,
                                 input logic err, input logic chk, input int cyc);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.err  = err;
    e.chk  = chk;
    e.cyc  = cyc;
    expQ.push_back(e);
  endfunction

  function automatic logic [31:0] shRead(input int a);
    if (shadow.exists(a)) return shadow[a];
    return mem[a];
  endfunction

  // Monitor: every bus access or done pulse must match the head of the queue,
  // including the cycle it appears in; anything with an empty queue is extra.
  always @(negedge clk) begin
    int          aKind;
    logic [31:0] aData;
    logic        ok;
    ev_t         e;
    if (reset_n) begin
      if (error && !done) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL errNoDone: error=1 done=0 at cyc %0d, required error only with done", cycNum);
      end
      if (m_chipselect || done) begin
        aKind = done ? 2 : (m_write ? 1 : 0);
        aData = done ? checksum : m_writedata;
        vecCount++;
        if (expQ.size() == 0) begin
          missCount++;
          $display("[TB] FAIL unexpected: kind=%0d addr=%h data=%h at cyc %0d, required no activity",
                   aKind, m_address, aData, cycNum);
        end else begin
          e  = expQ.pop_front();
          ok = (aKind == e.kind) && (cycNum == e.cyc) && busy;
          if (e.kind != 2) ok &= (int'(m_address) == e.addr);
          if (e.kind == 1) ok &= (m_writedata == e.data);
          if (e.kind == 2) ok &= (error == e.err) && (!e.chk || (checksum == e.data));
          if (!ok) begin
            missCount++;
            $display("[TB] FAIL event: got kind=%0d addr=%h data=%h err=%b busy=%b cyc=%0d, required kind=%0d addr=%h data=%h err=%b busy=1 cyc=%0d",
                     aKind, m_address, aData, error, busy, cycNum,
                     e.kind, e.addr, e.data, e.err, e.cyc);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Issues one command and queues the accesses the engine owes for it:
  // FILL writes at T+1..T+N, COPY reads/writes alternate from T+1, CHECKSUM
  // reads at T+1..T+N with done one cycle after the final data word.
  task automatic applyStimulus(input logic [1:0] m, input int src, input int dst,
                               input int len, input logic [31:0] fd);
    int          e;
    logic        rej;
    logic [31:0] v;
    logic [31:0] sum;
    @(negedge clk);
    mode      = m;
    src_addr  = ADDR_W'(src);
    dst_addr  = ADDR_W'(dst);
    length    = 16'(len);
    fill_data = fd;
    start     = 1'b1;
    e = cycNum + 1;
    shadow.delete();
    rej = (m == 2'd3) ||
          (((m == 2'd1) || (m == 2'd2)) && (src + len > DEPTH)) ||
          (((m == 2'd0) || (m == 2'd1)) && (dst + len > DEPTH));
    if (rej || (len == 0)) begin
      pushEv(2, 0, 32'h0, rej, 1'b0, e);
    end else if (m == 2'd0) begin
      for (int i = 0; i < len; i++) pushEv(1, dst + i, fd, 1'b0, 1'b0, e + i);
      pushEv(2, 0, 32'h0, 1'b0, 1'b0, e + len);
    end else if (m == 2'd1) begin
      for (int i = 0; i < len; i++) begin
        v = shRead(src + i);
        shadow[dst + i] = v;
        pushEv(0, src + i, 32'h0, 1'b0, 1'b0, e + 2 * i);
        pushEv(1, dst + i, v, 1'b0, 1'b0, e + 2 * i + 1);
      end
      pushEv(2, 0, 32'h0, 1'b0, 1'b0, e + 2 * len);
    end else begin
      sum = 32'h0;
      for (int i = 0; i < len; i++) begin
        sum = sum + shRead(src + i);
        pushEv(0, src + i, 32'h0, 1'b0, 1'b0, e + i);
      end
      pushEv(2, 0, sum, 1'b0, 1'b1, e + len + 1);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL %s timeout: %0d events pending, required 0", name, expQ.size());
      expQ.delete();
    end
    @(negedge clk);
    checkOutput({name, "Busy"}, {31'b0, busy}, 32'h0);
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk);
    preWe   = 1'b1;
    preAddr = ADDR_W'(a);
    preData = d;
    @(negedge clk);
    preWe   = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Busy"},  {31'b0, busy},         32'h0);
    checkOutput({tag, "Done"},  {31'b0, done},         32'h0);
    checkOutput({tag, "Err"},   {31'b0, error},        32'h0);
    checkOutput({tag, "Cs"},    {31'b0, m_chipselect}, 32'h0);
    checkOutput({tag, "Wr"},    {31'b0, m_write},      32'h0);
    checkOutput({tag, "Addr"},  {17'b0, m_address},    32'h0);
    checkOutput({tag, "Wdata"}, m_writedata,           32'h0);
    checkOutput({tag, "Sum"},   checksum,              32'h0);
    checkOutput({tag, "Be"},    {28'b0, m_byteenable}, 32'hF);
    checkOutput({tag, "Clken"}, {31'b0, m_clken},      32'h1);
  endtask

  // Watchdog so a stuck engine still ends the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    mode      = 2'd0;
    src_addr  = '0;
    dst_addr  = '0;
    length    = '0;
    fill_data = '0;
    preWe     = 1'b0;
    preAddr   = '0;
    preData   = '0;
    repeat (3) @(negedge clk);
    checkResetState("por");
    reset_n = 1'b1;

    applyStimulus(2'd0, 0, 32'h100, 4, 32'hDEADBEEF);
    waitIdle("fill4");
    for (int i = 0; i < 4; i++) checkOutput("fillMem", mem[32'h100 + i], 32'hDEADBEEF);

    preload(0, 32'd1);
    preload(1, 32'd2);
    preload(2, 32'd3);
    applyStimulus(2'd1, 0, 32'h200, 3, 32'h0);
    waitIdle("copy3");
    checkOutput("copyMem0", mem[32'h200], 32'd1);
    checkOutput("copyMem1", mem[32'h201], 32'd2);
    checkOutput("copyMem2", mem[32'h202], 32'd3);

    preload(32'h10, 32'hFFFFFFFF);
    preload(32'h11, 32'd2);
    preload(32'h12, 32'd3);
    applyStimulus(2'd2, 32'h10, 0, 3, 32'h0);
    waitIdle("sum3");
    checkOutput("sumWrap", checksum, 32'h00000004);

    applyStimulus(2'd0, 0, 32030, 7, 32'h12345678);
    waitIdle("fillOob");
    applyStimulus(2'd0, 0, 32030, 6, 32'h12345678);
    waitIdle("fillEdge");
    checkOutput("fillEdgeMem", mem[32035], 32'h12345678);

    applyStimulus(2'd3, 0, 0, 4, 32'h0);
    waitIdle("mode3");
    applyStimulus(2'd0, 0, 32'h100, 0, 32'h55555555);
    waitIdle("len0");
    checkOutput("len0Mem", mem[32'h100], 32'hDEADBEEF);

    preload(32'h700, 32'h11111111);
    applyStimulus(2'd0, 0, 32'h600, 5, 32'hCAFE0000);
    mode      = 2'd0;
    dst_addr  = 15'h700;
    length    = 16'd2;
    fill_data = 32'h99999999;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle("busyStart");
    checkOutput("busyStartMem", mem[32'h700], 32'h11111111);
    checkOutput("sumHeld", checksum, 32'h00000004);

    preload(32'h300, 32'd7);
    preload(32'h301, 32'd8);
    preload(32'h302, 32'd9);
    preload(32'h303, 32'd10);
    applyStimulus(2'd1, 32'h300, 32'h301, 3, 32'h0);
    waitIdle("copyOvl");
    for (int i = 1; i < 4; i++) checkOutput("copyOvlMem", mem[32'h300 + i], 32'd7);

    applyStimulus(2'd2, 32035, 0, 2, 32'h0);
    waitIdle("sumOob");
    applyStimulus(2'd2, 32035, 0, 1, 32'h0);
    waitIdle("sumEdge");
    checkOutput("sumEdge", checksum, 32'h12345678);

    for (int i = 0; i < 4; i++) begin
      preload(32'h400 + i, 32'hA0 + i);
      preload(32'h500 + i, 32'h5A5A5A5A);
    end
    applyStimulus(2'd1, 32'h400, 32'h500, 4, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkResetState("midRst");
    expQ.delete();
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("partialMem0", mem[32'h500], 32'hA0);
    checkOutput("partialMem1", mem[32'h501], 32'h5A5A5A5A);

    applyStimulus(2'd0, 0, 32'h800, 2, 32'hBEEF0001);
    waitIdle("postRstFill");
    checkOutput("postRstMem0", mem[32'h800], 32'hBEEF0001);
    checkOutput("postRstMem1", mem[32'h801], 32'hBEEF0001);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
